// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  localparam logic [31:0] INSTR_BYTES      = 32'd4;
  localparam int          FETCH_FIFO_DEPTH = 2;
  localparam int          FETCH_INSTR_W    = 32;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]              pc;
    logic [FETCH_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry skid buffer between instruction memory and decode; flush wins over push/pop.
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_entry,
  output fetch_entry_t head_entry,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  localparam int PTR_W = $clog2(FETCH_FIFO_DEPTH);

  fetch_entry_t     slots [FETCH_FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [1:0]       count_q;
  logic             do_push;
  logic             do_pop;

  assign full       = (count_q == 2'(FETCH_FIFO_DEPTH));
  assign empty      = (count_q == 2'd0);
  assign count      = count_q;
  assign do_push    = push && (!full || pop);
  assign do_pop     = pop && !empty;
  assign head_entry = slots[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= 2'd0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + 2'(do_push) - 2'(do_pop);
    end
  end

  // storage carries no reset; occupancy alone decides what is visible
  always_ff @(posedge clk) begin
    if (do_push && !flush) slots[wr_ptr_q] <= push_entry;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, redirect handling and decode handshake over fetch_fifo.
// Define FETCH_MISALIGN_CHECK_EN to halt on redirects whose target is not word aligned.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          ADDRESS_WIDTH = 16,
  parameter int          DATA_WIDTH    = 32,
  parameter logic [31:0] RESET_PC      = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0]    imem_dout,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_instr,
  output logic [31:0]              out_pc,
  output logic                     misalign_err
);

  fetch_state_t             state_q;
  fetch_state_t             state_d;
  logic [31:0]              fpc_q;
  logic [31:0]              req_pc_q;
  logic [31:0]              target_pc;
  logic [ADDRESS_WIDTH-1:0] last_addr_q;
  logic                     in_flight_q;
  logic                     issue;
  logic                     flush;
  logic                     push;
  logic                     pop;
  logic                     redirect_take;
  logic                     misalign_hit;
  logic                     can_issue;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [1:0]               fifo_count;
  logic [1:0]               buffered;
  fetch_entry_t             push_entry;
  fetch_entry_t             head_entry;

  assign redirect_take = (state_q == RUN) && redirect_valid;
  assign target_pc     = redirect_pc & ~32'h3;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q;

  assign misalign_hit = redirect_take && (redirect_pc[1:0] != 2'b00);
  assign misalign_err = misalign_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               misalign_q <= 1'b0;
    else if (misalign_hit) misalign_q <= 1'b1;
  end
`else
  assign misalign_hit = 1'b0;
  assign misalign_err = 1'b0;
`endif

  // an entry leaving this cycle frees its slot for a request issued this cycle
  assign out_valid = (state_q == RUN) && !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign buffered  = fifo_count - {1'b0, pop};
  assign can_issue = !fifo_full && ((buffered + {1'b0, in_flight_q}) < 2'd2);
  assign push      = in_flight_q && !flush;

  assign imem_addr = issue ? fpc_q[ADDRESS_WIDTH+1:2] : last_addr_q;
  assign out_pc    = out_valid ? head_entry.pc : 32'h0;
  assign out_instr = out_valid ? DATA_WIDTH'(head_entry.instr) : '0;

  always_comb begin
    push_entry       = '0;
    push_entry.pc    = req_pc_q;
    push_entry.instr = FETCH_INSTR_W'(imem_dout);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= BOOT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (misalign_hit) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    issue = 1'b0;
    flush = 1'b0;
    unique case (state_q)
      BOOT: issue = 1'b1;
      RUN: begin
        flush = redirect_valid;
        issue = !redirect_valid && can_issue;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc_q       <= RESET_PC;
      in_flight_q <= 1'b0;
      last_addr_q <= RESET_PC[ADDRESS_WIDTH+1:2];
    end else begin
      in_flight_q <= issue;
      if (issue) begin
        fpc_q       <= fpc_q + INSTR_BYTES;
        last_addr_q <= fpc_q[ADDRESS_WIDTH+1:2];
      end else if (redirect_take) begin
        fpc_q <= target_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue) req_pc_q <= fpc_q;
  end

  fetch_fifo u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .flush      (flush),
    .push_entry (push_entry),
    .head_entry (head_entry),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit; memory word at word address a holds 32'h1000_0000 + a.
module tb_fetch_unit;

  localparam int          AW  = 16;
  localparam int          DW  = 32;
  localparam logic [31:0] RPC = 32'h0000_0000;
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_dout;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_pc = 32'h0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_instr;
  logic [31:0]   out_pc;
  logic          misalign_err;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(RPC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_dout      (imem_dout),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_dout <= 32'h1000_0000 + 32'(imem_addr);

  function automatic logic [31:0] word_of(input logic [31:0] pc);
    return 32'h1000_0000 + {16'h0, pc[AW+1:2]};
  endfunction

  task automatic do_reset();
    rst = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_pc(input logic [31:0] pc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = (out_valid === 1'b1) && (out_pc === pc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_instr !== '0 || out_pc !== 32'h0 || misalign_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b instr=%h pc=%h mis=%b, required all zero",
               out_valid, out_instr, out_pc, misalign_err);
    end
    checks++;
    if (imem_addr !== RPC[AW+1:2]) begin
      errors++;
      $display("FAIL reset_addr: got %h, required %h", imem_addr, RPC[AW+1:2]);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_latency_early: out_valid=%b one cycle after reset, required 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== RPC || out_instr !== word_of(RPC)) begin
      errors++;
      $display("FAIL first_instr: valid=%b pc=%h instr=%h, required 1 %h %h",
               out_valid, out_pc, out_instr, RPC, word_of(RPC));
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp = RPC;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_pc !== exp || out_instr !== word_of(exp)) begin
        errors++;
        $display("FAIL stream[%0d]: valid=%b pc=%h instr=%h, required 1 %h %h",
                 i, out_valid, out_pc, out_instr, exp, word_of(exp));
      end
      exp += 32'd4;
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [31:0] exp;
    logic [31:0] nxt;
    int n;
    do_reset();
    wait_pc(32'h8, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_wait: pc 0x8 never offered, required offered"); end
    @(negedge clk);
    out_ready = 1'b0;
    nxt = 32'h10;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'hC || out_instr !== word_of(32'hC) ||
          imem_addr !== nxt[AW+1:2]) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b pc=%h instr=%h addr=%h, required 1 0000000c %h %h",
                 i, out_valid, out_pc, out_instr, imem_addr, word_of(32'hC), nxt[AW+1:2]);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    exp = 32'hC;
    n = 0;
    for (int i = 0; i < 12 && n < 3; i++) begin
      if (out_valid === 1'b1) begin
        checks++;
        if (out_pc !== exp || out_instr !== word_of(exp)) begin
          errors++;
          $display("FAIL bp_resume: pc=%h instr=%h, required %h %h", out_pc, out_instr, exp, word_of(exp));
        end
        exp += 32'd4;
        n++;
      end
      @(negedge clk);
    end
    checks++;
    if (n != 3) begin errors++; $display("FAIL bp_resume_count: got %0d, required 3", n); end
  endtask

  task automatic test_redirect();
    bit ok;
    logic [31:0] exp;
    do_reset();
    wait_pc(32'h8, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL redir_wait: pc 0x8 never offered, required offered"); end
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_flush: valid=%b pc=%h after redirect, required valid 0", out_valid, out_pc);
    end
    @(negedge clk);
    @(negedge clk);
    exp = 32'h40;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_pc !== exp || out_instr !== word_of(exp)) begin
        errors++;
        $display("FAIL redir_seq[%0d]: valid=%b pc=%h instr=%h, required 1 %h %h",
                 i, out_valid, out_pc, out_instr, exp, word_of(exp));
      end
      exp += 32'd4;
      @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [31:0] exp;
    int n;
    do_reset();
    wait_pc(32'h4, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wrap_wait: pc 0x4 never offered, required offered"); end
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    @(negedge clk);
    redirect_valid = 1'b0;
    exp = 32'hFFFF_FFF8;
    n = 0;
    for (int i = 0; i < 12 && n < 3; i++) begin
      if (out_valid === 1'b1) begin
        checks++;
        if (out_pc !== exp || out_instr !== word_of(exp)) begin
          errors++;
          $display("FAIL wrap_seq: pc=%h instr=%h, required %h %h", out_pc, out_instr, exp, word_of(exp));
        end
        exp += 32'd4;
        n++;
      end
      @(negedge clk);
    end
    checks++;
    if (n != 3) begin errors++; $display("FAIL wrap_count: got %0d, required 3", n); end
  endtask

  task automatic test_misalign();
    bit ok;
    do_reset();
    wait_pc(32'h4, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mis_wait: pc 0x4 never offered, required offered"); end
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    @(negedge clk);
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (misalign_err !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mis_halt[%0d]: mis=%b valid=%b, required 1 0", i, misalign_err, out_valid);
      end
      @(negedge clk);
    end
`else
    ok = 1'b0;
    for (int i = 0; i < 6 && !ok; i++) begin
      checks++;
      if (misalign_err !== 1'b0) begin
        errors++;
        $display("FAIL mis_flag: got %b, required 0", misalign_err);
      end
      if (out_valid === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!ok || out_pc !== 32'h40 || out_instr !== word_of(32'h40)) begin
      errors++;
      $display("FAIL mis_target: valid=%b pc=%h instr=%h, required 1 00000040 %h",
               ok, out_pc, out_instr, word_of(32'h40));
    end
`endif
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    wait_pc(32'h4, ok);
    out_ready = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL rmid_wait: pc 0x4 never offered, required offered"); end
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h4) begin
      errors++;
      $display("FAIL rmid_full: valid=%b pc=%h, required 1 00000004", out_valid, out_pc);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_async: valid=%b, required 0", out_valid); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 32'h0 || misalign_err !== 1'b0) begin
      errors++;
      $display("FAIL rmid_next: valid=%b pc=%h mis=%b, required 0 0 0", out_valid, out_pc, misalign_err);
    end
    out_ready = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== RPC || out_instr !== word_of(RPC)) begin
      errors++;
      $display("FAIL rmid_restart: valid=%b pc=%h instr=%h, required 1 %h %h",
               out_valid, out_pc, out_instr, RPC, word_of(RPC));
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] prev_pc;
    logic [31:0] prev_instr;
    logic [31:0] tgt;
    bit          hold;
    int          idle;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    exp_pc = RPC; hold = 1'b0; idle = 0; tgt = 32'h0;
    for (int i = 0; i < 800; i++) begin
      if (hold) begin
        checks++;
        if (out_valid !== 1'b1 || out_pc !== prev_pc || out_instr !== prev_instr) begin
          errors++;
          $display("FAIL rnd_stable[%0d]: valid=%b pc=%h instr=%h, required 1 %h %h",
                   i, out_valid, out_pc, out_instr, prev_pc, prev_instr);
        end
      end
      if (out_valid === 1'b1) idle = 0;
      else idle++;
      if (idle > 4) begin
        checks++; errors++;
        $display("FAIL rnd_liveness[%0d]: %0d idle cycles, required at most 4", i, idle);
        idle = 0;
      end
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      if (redirect_valid) begin
        if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
        else tgt = $urandom;
        if (MIS_EN) tgt[1:0] = 2'b00;
        redirect_pc = tgt;
        exp_pc = tgt & ~32'h3;
        hold = 1'b0;
        idle = 0;
      end else begin
        if (out_valid === 1'b1) begin
          checks++;
          if (out_pc !== exp_pc || out_instr !== word_of(exp_pc)) begin
            errors++;
            $display("FAIL rnd_order[%0d]: pc=%h instr=%h, required %h %h",
                     i, out_pc, out_instr, exp_pc, word_of(exp_pc));
          end
          if (out_ready) exp_pc += 32'd4;
        end
        hold = (out_valid === 1'b1) && !out_ready;
      end
      prev_pc = out_pc;
      prev_instr = out_instr;
      @(negedge clk);
    end
    redirect_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
